// File: rtl/text_vram_arbiter.sv
// Text-mode VRAM arbiter: one character-cell fetch per 9-pixel cell during active video,
// with host reads/writes slotted into the remaining memory cycles through a req/ack handshake.
module text_vram_arbiter #(
  parameter int COLS   = 80,
  parameter int ROWS   = 25,
  parameter int CELL_W = 9,
  parameter int CELL_H = 14,
  parameter int AW     = 11,
  parameter int DW     = 16
) (
  input  logic          pixelclk,
  input  logic          rst_n,
  input  logic [31:0]   row,
  input  logic [31:0]   col,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] cell_data,
  output logic          cell_valid,
  output logic [3:0]    glyph_line
);

  localparam int PW = (CELL_W > 1) ? $clog2(CELL_W) : 1;
  localparam int LW = (CELL_H > 1) ? $clog2(CELL_H) : 1;

  localparam logic [31:0]   ACT_ROWS   = 32'(ROWS * CELL_H);
  localparam logic [31:0]   ACT_COLS   = 32'(COLS * CELL_W);
  localparam logic [AW:0]   NCELLS     = (AW + 1)'(COLS * ROWS);
  localparam logic [PW-1:0] PHASE_LAST = PW'(CELL_W - 1);
  localparam logic [LW-1:0] LINE_LAST  = LW'(CELL_H - 1);
  localparam logic [AW-1:0] ROW_STRIDE = AW'(COLS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  logic [PW-1:0] phase_q, cur_phase;
  logic [AW-1:0] cell_q, cur_cell;
  logic [LW-1:0] line_q, cur_line;
  logic [AW-1:0] base_q, cur_base;
  logic          col_sync;

  logic          col_zero, row_zero;
  logic          slot;
  logic [AW-1:0] fetch_addr;

  logic [1:0]    state;
  logic          rd_ok;
  logic          host_go;
  logic          in_range;

  logic          fetch_d1, fetch_d2;
  logic [LW-1:0] glyph_d1, glyph_d2;

  assign col_zero = (col == 32'd0);
  assign row_zero = (row == 32'd0);

  // The registered counters hold values for the current scanline/column; col 0 re-derives them
  // so the counters self-align to the timing generator without any division.
  always_comb begin
    cur_phase = phase_q;
    cur_cell  = cell_q;
    cur_line  = line_q;
    cur_base  = base_q;
    if (col_zero) begin
      cur_phase = '0;
      cur_cell  = '0;
      if (row_zero) begin
        cur_line = '0;
        cur_base = '0;
      end else if (line_q == LINE_LAST) begin
        cur_line = '0;
        cur_base = base_q + ROW_STRIDE;
      end else begin
        cur_line = line_q + LW'(1);
      end
    end
  end

  assign fetch_addr = cur_base + cur_cell;

  // After reset the column phase is unknown until the next col 0, so no fetch before then.
  assign slot = (col_sync || col_zero) && (row < ACT_ROWS) && (col < ACT_COLS) &&
                (cur_phase == '0);

  assign in_range = ({1'b0, host_addr} < NCELLS);
  assign host_go  = (state == S_IDLE) && host_req && !slot;

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= '0;
      cell_q   <= '0;
      line_q   <= '0;
      base_q   <= '0;
      col_sync <= 1'b0;
    end else begin
      if (col_zero) begin
        col_sync <= 1'b1;
      end
      if (cur_phase == PHASE_LAST) begin
        phase_q <= '0;
        cell_q  <= cur_cell + AW'(1);
      end else begin
        phase_q <= cur_phase + PW'(1);
        cell_q  <= cur_cell;
      end
      line_q <= cur_line;
      base_q <= cur_base;
    end
  end

  // Display owns the memory in the cycle after a slot; host ops only load in non-slot cycles.
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (slot) begin
      mem_en    <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= fetch_addr;
      mem_wdata <= '0;
    end else if (host_go) begin
      mem_en    <= in_range;
      mem_we    <= in_range && host_we;
      mem_addr  <= host_addr;
      mem_wdata <= host_we ? host_wdata : '0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end
  end

  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rd_ok <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (host_go) begin
            state <= S_ISSUE;
            rd_ok <= in_range && !host_we;
          end
        end
        S_ISSUE: state <= S_ACK;
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign host_ack   = (state == S_ACK);
  assign host_rdata = (host_ack && rd_ok) ? mem_rdata : '0;

  // Fetch result lands two cycles after the slot and is registered once more for a fixed 3-pixel latency.
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_d1   <= 1'b0;
      fetch_d2   <= 1'b0;
      glyph_d1   <= '0;
      glyph_d2   <= '0;
      cell_valid <= 1'b0;
      cell_data  <= '0;
      glyph_line <= '0;
    end else begin
      fetch_d1   <= slot;
      glyph_d1   <= cur_line;
      fetch_d2   <= fetch_d1;
      glyph_d2   <= glyph_d1;
      cell_valid <= fetch_d2;
      if (fetch_d2) begin
        cell_data  <= mem_rdata;
        glyph_line <= 4'(glyph_d2);
      end
    end
  end

endmodule

// File: tb/tb_text_vram_arbiter.sv
// Directed bench for text_vram_arbiter: drives the row/col raster, models the VRAM, and
// scoreboards every display fetch against an address model computed with plain division.
module tb_text_vram_arbiter;

  localparam int AW = 11;
  localparam int DW = 16;

  logic          pixelclk = 1'b0;
  logic          rst_n;
  logic [31:0]   row, col;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] cell_data;
  logic          cell_valid;
  logic [3:0]    glyph_line;

  text_vram_arbiter dut (
    .pixelclk(pixelclk), .rst_n(rst_n), .row(row), .col(col),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cell_data(cell_data), .cell_valid(cell_valid), .glyph_line(glyph_line)
  );

  always #5 pixelclk = ~pixelclk;

  function automatic logic [15:0] pat(input int a);
    return 16'(a * 7) ^ 16'h5A00;
  endfunction

  // VRAM model: unwritten words read back as the fill pattern.
  logic [DW-1:0] vram [0:2047];
  bit            written [0:2047];
  int            hits = 0;

  always @(posedge pixelclk) begin
    if (mem_en) begin
      if (mem_we) begin
        vram[mem_addr]    <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end
      mem_rdata <= mem_we ? mem_wdata : (written[mem_addr] ? vram[mem_addr] : pat(int'(mem_addr)));
      if (mem_addr >= 11'd100 && mem_addr <= 11'd102) hits <= hits + 1;
    end
  end

  typedef struct {
    int addr;
    int glyph;
    int due;
  } fetch_t;

  fetch_t        sb[$];
  logic [DW-1:0] shadow [0:2047];
  int            checks = 0;
  int            errors = 0;
  int            cycle = 0;
  int            cur_row = 0;
  int            cur_col = 0;
  bit            quiet = 1'b1;
  int            last_ack;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    fetch_t f;
    bit     slot_now;
    slot_now = rst_n && (cur_row < 350) && (cur_col < 720) && (cur_col % 9 == 0);
    if (slot_now) begin
      f.addr  = (cur_row / 14) * 80 + cur_col / 9;
      f.glyph = cur_row % 14;
      f.due   = cycle + 3;
      sb.push_back(f);
    end
    @(posedge pixelclk);
    #1;
    cycle++;
    if (slot_now) begin
      chk("fetch_mem_en", mem_en, 1);
      chk("fetch_mem_we", mem_we, 0);
      chk("fetch_addr", mem_addr, f.addr);
    end else if (quiet) begin
      chk("idle_mem_en", mem_en, 0);
      chk("idle_ack", host_ack, 0);
    end
    if (sb.size() > 0 && sb[0].due == cycle) begin
      f = sb.pop_front();
      chk("cell_valid", cell_valid, 1);
      chk("cell_data", cell_data, shadow[f.addr]);
      chk("glyph_line", glyph_line, f.glyph);
    end else begin
      chk("cell_valid_idle", cell_valid, 0);
    end
  endtask

  task automatic adv();
    row = 32'(cur_row);
    col = 32'(cur_col);
    tick();
    cur_col++;
  endtask

  task automatic run_to(input int c_end);
    while (cur_col <= c_end) adv();
  endtask

  task automatic goto_row(input int r);
    cur_row = r;
    cur_col = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, host_ack, 0);
    chk({tag, "_rdata"}, host_rdata, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_cell_data"}, cell_data, 0);
    chk({tag, "_cell_valid"}, cell_valid, 0);
    chk({tag, "_glyph"}, glyph_line, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) shadow[i] = pat(i);
    rst_n = 1'b1;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    row = '0; col = '0;

    // Power-on reset
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    @(posedge pixelclk);
    @(posedge pixelclk);
    #1 rst_n = 1'b1;

    // Row 0: first fetch and its latency
    goto_row(0);
    adv();
    chk("r0c0_addr", mem_addr, 0);
    run_to(2);
    chk("r0c0_valid", cell_valid, 1);
    chk("r0c0_glyph", glyph_line, 0);

    // Host write in a free cycle
    quiet = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 11'd5; host_wdata = 16'h4141;
    shadow[5] = 16'h4141;
    adv();
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 5);
    chk("wr_mem_wdata", mem_wdata, 16'h4141);
    chk("wr_ack_early", host_ack, 0);
    adv();
    chk("wr_ack", host_ack, 1);
    chk("wr_rdata", host_rdata, 0);
    host_req = 1'b0;

    // Collision: read request first seen in a slot cycle
    run_to(8);
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'd5;
    adv();
    chk("coll_disp_addr", mem_addr, 1);
    chk("coll_ack_early", host_ack, 0);
    adv();
    chk("coll_host_en", mem_en, 1);
    chk("coll_host_addr", mem_addr, 5);
    chk("coll_host_we", mem_we, 0);
    adv();
    chk("coll_ack", host_ack, 1);
    chk("coll_rdata", host_rdata, 16'h4141);
    chk("coll_cell_valid", cell_valid, 1);
    host_req = 1'b0;

    // Out-of-range write and read
    run_to(19);
    host_req = 1'b1; host_we = 1'b1; host_addr = 11'd2000; host_wdata = 16'h1234;
    adv();
    chk("oor_wr_mem_en", mem_en, 0);
    chk("oor_wr_mem_we", mem_we, 0);
    chk("oor_wr_ack_early", host_ack, 0);
    adv();
    chk("oor_wr_ack", host_ack, 1);
    host_req = 1'b0;
    run_to(29);
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'd2047;
    adv();
    chk("oor_rd_mem_en", mem_en, 0);
    adv();
    chk("oor_rd_ack", host_ack, 1);
    chk("oor_rd_rdata", host_rdata, 0);
    host_req = 1'b0;

    // Back-to-back reads with req held high
    run_to(39);
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'd100;
    last_ack = -100;
    for (int op = 0; op < 3; op++) begin
      int n;
      n = 0;
      do begin
        adv();
        n++;
      end while (host_ack !== 1'b1 && n < 10);
      chk("b2b_ack", host_ack, 1);
      chk("b2b_rdata", host_rdata, shadow[100 + op]);
      if (op > 0) chk("b2b_gap", 32'((cycle - last_ack) >= 3), 1);
      last_ack = cycle;
      host_addr = 11'(101 + op);
    end
    host_req = 1'b0;
    run_to(cur_col + 2);
    chk("b2b_hits", hits, 3);
    quiet = 1'b1;

    // Rest of row 0, then reset while a host read is in ISSUE
    run_to(749);
    quiet = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 11'd7;
    adv();
    chk("rst_issue_en", mem_en, 1);
    chk("rst_issue_addr", mem_addr, 7);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("midreset");
    host_req = 1'b0;
    sb.delete();
    quiet = 1'b1;
    run_to(753);
    rst_n = 1'b1;
    run_to(879);

    // Row 1: first slot after release
    goto_row(1);
    run_to(2);
    chk("r1_valid", cell_valid, 1);
    chk("r1_glyph", glyph_line, 1);

    for (int r = 2; r <= 12; r++) begin
      goto_row(r);
      run_to(0);
    end

    // Row 13, last cell
    goto_row(13);
    run_to(711);
    chk("r13c711_addr", mem_addr, 79);
    run_to(713);
    chk("r13c711_glyph", glyph_line, 13);
    chk("r13c711_data", cell_data, shadow[79]);
    run_to(879);

    goto_row(14);
    run_to(0);
    chk("r14c0_addr", mem_addr, 80);

    for (int r = 15; r <= 348; r++) begin
      goto_row(r);
      run_to(0);
    end

    goto_row(349);
    run_to(711);
    chk("r349c711_addr", mem_addr, 1999);
    run_to(879);

    // Vertical blanking: no fetches at all
    goto_row(350);
    run_to(879);
    for (int r = 351; r <= 369; r++) begin
      goto_row(r);
      run_to(0);
    end

    // Frame wrap
    goto_row(0);
    run_to(0);
    chk("wrap_addr", mem_addr, 0);
    run_to(14);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_vram_arbiter.md
# text_vram_arbiter

Shares one single-port 16-bit text VRAM between the display character fetch and a host read/write port, for the 720x350 text-mode pipeline (80x25 cells of 9x14 pixels). It follows the display timing generator's row/col counters, issues one character-cell read per 9-pixel cell during active video, and gives every other memory cycle to the host. The display always wins a memory cycle; the host is served through a req/ack handshake.

## Interface
- COLS, 80: character cells per text row
- ROWS, 25: text rows
- CELL_W, 9: pixels per cell horizontally
- CELL_H, 14: scanlines per cell
- AW, 11: VRAM address width; must hold COLS*ROWS-1
- DW, 16: VRAM word width (char code [7:0], attribute [15:8])

Ports:
- pixelclk  in  1  pixel clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- row  in  32  current scanline from the timing generator (0..369)
- col  in  32  current pixel column from the timing generator (0..879)
- host_req  in  1  host request; level, held with addr/we/wdata stable until host_ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  AW  host cell address
- host_wdata  in  DW  host write data
- host_ack  out  1  one-cycle completion pulse
- host_rdata  out  DW  read data, valid only while host_ack is high
- mem_en, mem_we  out  1 each  VRAM enable and write strobe
- mem_addr  out  AW  VRAM address
- mem_wdata  out  DW  VRAM write data
- mem_rdata  in  DW  VRAM read data, one cycle after mem_en
- cell_data  out  DW  fetched cell word
- cell_valid  out  1  one-cycle pulse, cell_data updated
- glyph_line  out  4  row mod CELL_H for the fetched cell

## Operation
- Display slot: the cycle in which row < ROWS*CELL_H, col < COLS*CELL_W, and col mod CELL_W == 0. With the defaults this is col = 9k, k = 0..79, rows 0..349.
- Fetch address = (row / CELL_H) * COLS + (col / CELL_W).
  - No dividers. Track the text row base with counters: base += COLS after every CELL_H scanlines, and base = 0 at row 0.
  - Track the cell index with a phase counter 0..CELL_W-1 that restarts at col 0.
- No fetches in blanking (row ≥ 350 or col ≥ 720).
- All mem_* outputs are registered.
- Host FSM states are IDLE, ISSUE and ACK.
  - IDLE → ISSUE when host_req is high in a non-slot cycle. The host op is loaded onto mem_* at that edge.
  - ISSUE → ACK unconditionally.
  - ACK → IDLE unconditionally.
- host_req is ignored in ISSUE and ACK, so there is no double issue while req is still high in the ack cycle. Maximum host rate is one op per 3 cycles.
- A host request that arrives in a slot cycle waits. It issues at the first non-slot cycle, which is at most one cycle later.
- If host_addr ≥ COLS*ROWS:
  - mem_en stays 0 for that op;
  - host_ack is still pulsed at the normal time;
  - host_rdata reads 0.
- host_rdata = mem_rdata when the ack is for a valid read. It is 0 when the ack is for a write or an out-of-range read.
- mem_wdata = host_wdata for host writes and 0 otherwise. mem_we is 1 only for in-range host writes.

## Timing
- Reset (async assert): every output is 0 (host_ack, host_rdata, mem_en, mem_we, mem_addr, mem_wdata, cell_data, cell_valid, glyph_line). FSM goes to IDLE and counters clear.
- Reset mid-operation: any pending ack is dropped, with no late ack after release. The host must re-request.
- Display fetch, for a slot at cycle col = c:
  - mem_en = 1 and mem_addr = fetch address during c+1;
  - mem_rdata is valid at c+2;
  - cell_data, glyph_line and cell_valid are registered and visible during c+3.
  - Fixed latency is 3 pixels; downstream compensates.
- Host op, for a request seen in non-slot cycle t:
  - mem_* drive the op during t+1;
  - host_ack = 1 during t+2, and read data is valid then;
  - FSM is back in IDLE for cycle t+3.
- Collision: host issue in cycle c+1 is impossible when c is a slot, because mem_* are owned by the display during c+1. Any host op loaded at the edge ending cycle c-1 occupies mem_* in cycle c, not c+1.
- Row wrap (row 369 → 0) and col wrap (879 → 0) need no special handling beyond the counter resets.

## Test plan
- Reset: assert rst_n = 0 mid-frame with a host read in ISSUE → all outputs 0 immediately; release → no host_ack, and the first fetch occurs at the next slot.
- Fetch addressing:
  - row 0, col 0 → mem_addr 0 at col 1, cell_valid at col 3, glyph_line 0.
  - row 13, col 711 → addr 79, glyph_line 13.
  - row 14, col 0 → addr 80.
  - row 349, col 711 → addr 1999.
  - No mem_en from fetches at row 350 or at cols 720..879.
- Host write in a free cycle: req at col 3, addr 5, data 0x4141 → mem_we = 1 at col 4 with addr 5; host_ack at col 5; a subsequent display fetch of cell 5 returns 0x4141.
- Collision: host read req first high at col 9 (a slot) → display fetch drives mem_* at col 10, host read at col 11, host_ack at col 12 with correct data; cell_valid still at col 12.
- Out-of-range: host write to addr 2000 → no mem_en, ack after 2 cycles. Host read to addr 2047 → ack with host_rdata 0.
- Back-to-back: host_req held high across 3 ops with new addresses after each ack → exactly one mem access per op, spaced ≥ 3 cycles.
